// File: rtl/sudoku_prop_ctrl.sv
// ---------------------------------------------------------------------------
// sudoku_prop_ctrl
//
// Runs the external combinational stage-2 mask propagator until the mask
// stops changing. The stage gets the registered mask and its result is
// captured once per cycle. The run stops on one of four conditions: solved,
// stuck, a conflicting cell, or the iteration limit. The final mask and a
// status code are then held for the consumer.
//
// Mask layout: bit i belongs to cell i/9 (x = i/81, y = (i/9)%9) and to value
// i%9. A 1 means the candidate is eliminated.
//
// Ports
//   clk         in   1       clock, all state on rising edge
//   rst         in   1       synchronous active-high reset
//   in_valid    in   1       in_mask valid
//   in_ready    out  1       block can accept a puzzle (IDLE only)
//   in_mask     in   729     starting candidate mask
//   stg_mask_o  out  729     registered mask driven into the stage-2 propagator
//   stg_mask_i  in   729     stage-2 result, combinational from stg_mask_o
//   out_valid   out  1       result valid
//   out_ready   in   1       consumer accepts result
//   out_mask    out  729     final mask (same register as stg_mask_o)
//   out_status  out  2       0 SOLVED, 1 STUCK, 2 CONFLICT, 3 TIMEOUT
//   out_iters   out  ITER_W  number of mask updates applied
//   busy        out  1       high while iterating
// ---------------------------------------------------------------------------
module sudoku_prop_ctrl #(
  parameter int MAX_ITER = 32,  // mask updates before TIMEOUT, 1..2**ITER_W-1
  parameter int ITER_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [728:0]      in_mask,
  output logic [728:0]      stg_mask_o,
  input  logic [728:0]      stg_mask_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [728:0]      out_mask,
  output logic [1:0]        out_status,
  output logic [ITER_W-1:0] out_iters,
  output logic              busy
);

  localparam int NCELL = 81;
  localparam int NVAL  = 9;
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_SOLVED   = 2'd0,
    ST_STUCK    = 2'd1,
    ST_CONFLICT = 2'd2,
    ST_TIMEOUT  = 2'd3
  } status_t;

  state_t              state, state_nxt;
  logic [728:0]        mask_r, mask_nxt;
  logic [ITER_W-1:0]   iter, iter_nxt, iter_inc;
  status_t             status_r, status_nxt;
  logic [ITER_W-1:0]   iters_r, iters_nxt;

  logic any_conflict;   // some cell of the stage result has every value eliminated
  logic all_single;     // every cell of the stage result has exactly one candidate left
  logic is_fixpoint;

  // Per-cell classification of the stage result. At a fixpoint the stage
  // result equals mask_r, so the solved test can use the same vector.
  always_comb begin
    // NOTE: every variable written here gets a value before any conditional
    // update, so no path leaves it unassigned and no latch is inferred.
    any_conflict = 1'b0;
    all_single   = 1'b1;
    for (int c = 0; c < NCELL; c++) begin
      if (&stg_mask_i[c*NVAL +: NVAL]) begin
        any_conflict = 1'b1;
      end
      if ($countones(stg_mask_i[c*NVAL +: NVAL]) != NVAL - 1) begin
        all_single = 1'b0;
      end
    end
  end

  assign is_fixpoint = (stg_mask_i == mask_r);
  assign iter_inc    = iter + ITER_W'(1);

  // Next-state and datapath update. Conflict is tested before fixpoint, and
  // only a real update advances the iteration count.
  always_comb begin
    state_nxt  = state;
    mask_nxt   = mask_r;
    iter_nxt   = iter;
    status_nxt = status_r;
    iters_nxt  = iters_r;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          mask_nxt  = in_mask;
          iter_nxt  = '0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (any_conflict) begin
          mask_nxt   = stg_mask_i;
          status_nxt = ST_CONFLICT;
          iters_nxt  = iter;
          state_nxt  = S_DONE;
        end else if (is_fixpoint) begin
          status_nxt = all_single ? ST_SOLVED : ST_STUCK;
          iters_nxt  = iter;
          state_nxt  = S_DONE;
        end else begin
          mask_nxt = stg_mask_i;
          iter_nxt = iter_inc;
          if (iter_inc == ITER_LIMIT) begin
            status_nxt = ST_TIMEOUT;
            iters_nxt  = iter_inc;
            state_nxt  = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Return to IDLE only; a new puzzle is taken on a later edge.
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= S_IDLE;
      // NOTE: the 729-bit mask is plain flops, not a RAM, so clearing it on
      // reset is cheap and keeps stg_mask_o defined for the stage after reset.
      mask_r   <= '0;
      iter     <= '0;
      status_r <= ST_SOLVED;
      iters_r  <= '0;
    end else begin
      state    <= state_nxt;
      mask_r   <= mask_nxt;
      iter     <= iter_nxt;
      status_r <= status_nxt;
      iters_r  <= iters_nxt;
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state == S_RUN);
  assign out_valid  = (state == S_DONE);
  assign stg_mask_o = mask_r;
  assign out_mask   = mask_r;
  assign out_status = status_r;
  assign out_iters  = iters_r;

endmodule
